// File: rtl/ysyx_25060170_arb_pkg.sv
// Shared encodings and default widths for the IFU/LSU data-memory arbiter.
package ysyx_25060170_arb_pkg;

   localparam int unsigned ARB_ADDR_W = 32;
   localparam int unsigned ARB_DATA_W = 64;
   localparam int unsigned TMR_W      = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } arb_state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_LS = 1'b1
   } arb_owner_e;

endpackage

// File: rtl/ysyx_25060170_arb_pick.sv
// Combinational winner selection between IF and LS requests.
// YSYX_25060170_ARB_RR_EN selects round-robin on ties; otherwise LS has fixed priority.
module ysyx_25060170_arb_pick
   import ysyx_25060170_arb_pkg::*;
(
   input  logic if_req_i,
   input  logic ls_req_i,
`ifdef YSYX_25060170_ARB_RR_EN
   input  logic last_i,
`endif
   output logic owner_o
);

   always_comb begin
      owner_o = OWN_IF;
`ifdef YSYX_25060170_ARB_RR_EN
      // On a tie, LS wins only if IF was served last.
      if (ls_req_i && (!if_req_i || (last_i == OWN_IF))) owner_o = OWN_LS;
`else
      if (ls_req_i) owner_o = OWN_LS;
`endif
   end

endmodule

// File: rtl/ysyx_25060170_mem_arb.sv
// Two-requester (IFU read-only, LSU read/write) arbiter for one data-memory port.
// One outstanding transaction; aborts on response timeout. Round-robin via YSYX_25060170_ARB_RR_EN.
module ysyx_25060170_mem_arb
   import ysyx_25060170_arb_pkg::*;
#(
   parameter int unsigned ADDR_W  = ARB_ADDR_W,
   parameter int unsigned DATA_W  = ARB_DATA_W,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                clk_i,
   input  logic                rst_i,

   input  logic                if_req_i,
   input  logic [ADDR_W-1:0]   if_addr_i,
   output logic                if_gnt_o,
   output logic                if_rvalid_o,
   output logic [DATA_W-1:0]   if_rdata_o,
   output logic                if_err_o,

   input  logic                ls_req_i,
   input  logic                ls_we_i,
   input  logic [ADDR_W-1:0]   ls_addr_i,
   input  logic [DATA_W-1:0]   ls_wdata_i,
   input  logic [DATA_W/8-1:0] ls_wmask_i,
   output logic                ls_gnt_o,
   output logic                ls_rvalid_o,
   output logic [DATA_W-1:0]   ls_rdata_o,
   output logic                ls_err_o,

   output logic                mem_req_o,
   output logic                mem_we_o,
   output logic [ADDR_W-1:0]   mem_addr_o,
   output logic [DATA_W-1:0]   mem_wdata_o,
   output logic [DATA_W/8-1:0] mem_wmask_o,
   input  logic                mem_gnt_i,
   input  logic                mem_rvalid_i,
   input  logic [DATA_W-1:0]   mem_rdata_i,

   output logic                busy_o
);

   localparam int unsigned      MASK_W   = DATA_W / 8;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
   localparam logic [TMR_W-1:0] TMR_MAX  = '1;

   arb_state_e       state_q;
   logic             owner_q;
   logic             owner_d;
   logic [TMR_W-1:0] timer_q;

   logic             in_req;
   logic             in_resp;
   logic             own_ls;
   logic             hs;
   logic             done_ok;
   logic             done_err;
   logic             done;
   logic [DATA_W-1:0] rdata_route;

`ifdef YSYX_25060170_ARB_RR_EN
   logic             last_q;

   ysyx_25060170_arb_pick u_pick (
      .if_req_i (if_req_i),
      .ls_req_i (ls_req_i),
      .last_i   (last_q),
      .owner_o  (owner_d)
   );
`else
   ysyx_25060170_arb_pick u_pick (
      .if_req_i (if_req_i),
      .ls_req_i (ls_req_i),
      .owner_o  (owner_d)
   );
`endif

   // Handshake and completion qualifiers; a cycle with rst_i high never pulses.
   assign in_req   = (state_q == ST_REQ);
   assign in_resp  = (state_q == ST_RESP);
   assign own_ls   = (owner_q == OWN_LS);
   assign hs       = in_req && mem_gnt_i && !rst_i;
   assign done_ok  = in_resp && mem_rvalid_i && !rst_i;
   assign done_err = in_resp && !mem_rvalid_i && (timer_q == TMR_LAST) && !rst_i;
   assign done     = done_ok || done_err;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         owner_q <= OWN_IF;
         timer_q <= '0;
`ifdef YSYX_25060170_ARB_RR_EN
         last_q  <= OWN_IF;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (if_req_i || ls_req_i) begin
                  owner_q <= owner_d;
`ifdef YSYX_25060170_ARB_RR_EN
                  last_q  <= owner_d;
`endif
                  state_q <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (mem_gnt_i) begin
                  timer_q <= '0;
                  state_q <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (done) begin
                  state_q <= ST_IDLE;
               end else if (timer_q != TMR_MAX) begin
                  timer_q <= timer_q + TMR_W'(1);
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Request payload comes straight from the owner's held inputs; IF never writes.
   assign mem_req_o   = in_req;
   assign mem_we_o    = in_req && own_ls && ls_we_i;
   assign mem_addr_o  = !in_req ? '0 : (own_ls ? ls_addr_i : if_addr_i);
   assign mem_wdata_o = (in_req && own_ls) ? ls_wdata_i : '0;
   assign mem_wmask_o = (in_req && own_ls) ? ls_wmask_i : MASK_W'(0);

   assign rdata_route = done_ok ? mem_rdata_i : '0;

   assign if_gnt_o    = hs && !own_ls;
   assign if_rvalid_o = done && !own_ls;
   assign if_err_o    = done_err && !own_ls;
   assign if_rdata_o  = own_ls ? '0 : rdata_route;

   assign ls_gnt_o    = hs && own_ls;
   assign ls_rvalid_o = done && own_ls;
   assign ls_err_o    = done_err && own_ls;
   assign ls_rdata_o  = own_ls ? rdata_route : '0;

   assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ysyx_25060170_mem_arb.sv
// Self-checking bench for ysyx_25060170_mem_arb with TIMEOUT=4; responses checked via a scoreboard queue.
module tb_ysyx_25060170_mem_arb;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 64;
   localparam int unsigned MW = DW / 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          if_req, ls_req, ls_we, mem_gnt, mem_rvalid;
   logic [AW-1:0] if_addr, ls_addr;
   logic [DW-1:0] ls_wdata, mem_rdata;
   logic [MW-1:0] ls_wmask;

   logic          if_gnt_o, if_rvalid_o, if_err_o;
   logic          ls_gnt_o, ls_rvalid_o, ls_err_o;
   logic [DW-1:0] if_rdata_o, ls_rdata_o, mem_wdata_o;
   logic          mem_req_o, mem_we_o, busy_o;
   logic [AW-1:0] mem_addr_o;
   logic [MW-1:0] mem_wmask_o;

   typedef struct {
      logic          own_ls;
      logic [DW-1:0] rdata;
      logic          err;
   } rsp_t;

   rsp_t sb_q[$];
   rsp_t mon_e;
   int   n_checks = 0;
   int   n_errs   = 0;

   always #5 clk = ~clk;

   ysyx_25060170_mem_arb #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .if_req_i     (if_req),
      .if_addr_i    (if_addr),
      .if_gnt_o     (if_gnt_o),
      .if_rvalid_o  (if_rvalid_o),
      .if_rdata_o   (if_rdata_o),
      .if_err_o     (if_err_o),
      .ls_req_i     (ls_req),
      .ls_we_i      (ls_we),
      .ls_addr_i    (ls_addr),
      .ls_wdata_i   (ls_wdata),
      .ls_wmask_i   (ls_wmask),
      .ls_gnt_o     (ls_gnt_o),
      .ls_rvalid_o  (ls_rvalid_o),
      .ls_rdata_o   (ls_rdata_o),
      .ls_err_o     (ls_err_o),
      .mem_req_o    (mem_req_o),
      .mem_we_o     (mem_we_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_wmask_o  (mem_wmask_o),
      .mem_gnt_i    (mem_gnt),
      .mem_rvalid_i (mem_rvalid),
      .mem_rdata_i  (mem_rdata),
      .busy_o       (busy_o)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Every response pulse must match the oldest expected entry.
   always @(negedge clk) begin
      if (if_rvalid_o || ls_rvalid_o) begin
         if (sb_q.size() == 0) begin
            check("rvalid_unexpected", 64'({if_rvalid_o, ls_rvalid_o}), '0);
         end else begin
            mon_e = sb_q.pop_front();
            check("rsp_ls_rvalid", 64'(ls_rvalid_o), 64'(mon_e.own_ls));
            check("rsp_if_rvalid", 64'(if_rvalid_o), 64'(!mon_e.own_ls));
            check("rsp_rdata", mon_e.own_ls ? ls_rdata_o : if_rdata_o, mon_e.rdata);
            check("rsp_other_rdata", mon_e.own_ls ? if_rdata_o : ls_rdata_o, '0);
            check("rsp_err", 64'(mon_e.own_ls ? ls_err_o : if_err_o), 64'(mon_e.err));
            check("rsp_other_err", 64'(mon_e.own_ls ? if_err_o : ls_err_o), '0);
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic push_rsp(input logic own_ls, input logic [DW-1:0] rd, input logic err);
      rsp_t e;
      e.own_ls = own_ls;
      e.rdata  = rd;
      e.err    = err;
      sb_q.push_back(e);
   endtask

   // Single transaction from IDLE; non-owner LS payload still driven to prove it is masked.
   task automatic txn(input logic is_ls, input logic we, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wd, input logic [MW-1:0] wm,
                      input int gnt_dly, input int rsp_dly, input logic [DW-1:0] rd);
      if (is_ls) begin
         ls_req  = 1'b1;
         ls_addr = addr;
      end else begin
         if_req  = 1'b1;
         if_addr = addr;
      end
      ls_we    = we;
      ls_wdata = wd;
      ls_wmask = wm;
      @(negedge clk);
      check("idle_busy", 64'(busy_o), '0);
      check("idle_mem_req", 64'(mem_req_o), '0);
      next_cycle();
      for (int i = 0; i <= gnt_dly; i++) begin
         mem_gnt = (i == gnt_dly);
         @(negedge clk);
         check("req_mem_req", 64'(mem_req_o), 64'd1);
         check("req_addr", 64'(mem_addr_o), 64'(addr));
         check("req_we", 64'(mem_we_o), 64'(is_ls & we));
         check("req_wdata", mem_wdata_o, is_ls ? wd : '0);
         check("req_wmask", 64'(mem_wmask_o), 64'(is_ls ? wm : MW'(0)));
         check("req_own_gnt", 64'(is_ls ? ls_gnt_o : if_gnt_o), 64'(i == gnt_dly));
         check("req_other_gnt", 64'(is_ls ? if_gnt_o : ls_gnt_o), '0);
         next_cycle();
      end
      mem_gnt = 1'b0;
      if_req  = 1'b0;
      ls_req  = 1'b0;
      for (int i = 0; i <= rsp_dly; i++) begin
         mem_rvalid = (i == rsp_dly);
         mem_rdata  = rd;
         if (i == rsp_dly) push_rsp(is_ls, rd, 1'b0);
         @(negedge clk);
         check("resp_busy", 64'(busy_o), 64'd1);
         check("resp_mem_req", 64'(mem_req_o), '0);
         next_cycle();
      end
      mem_rvalid = 1'b0;
      @(negedge clk);
      check("done_busy", 64'(busy_o), '0);
      next_cycle();
   endtask

   initial begin
      logic exp_ls;
      rst = 1'b1;
      if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if_addr = '0; ls_addr = '0; ls_wdata = '0; ls_wmask = '0; mem_rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("reset_outputs", 64'(|{mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
                                    if_gnt_o, if_rvalid_o, if_err_o, if_rdata_o,
                                    ls_gnt_o, ls_rvalid_o, ls_err_o, ls_rdata_o}), '0);
      check("reset_busy", 64'(busy_o), '0);
      next_cycle();

      // LS load, immediate grant and response
      txn(1'b1, 1'b0, 32'h8000_0010, 64'h0, 8'h00, 0, 0, 64'h1122_3344_5566_7788);
      // IF fetch while LS payload holds store junk
      txn(1'b0, 1'b1, 32'h8000_0400, 64'hFFFF_0000_FFFF_0000, 8'hFF, 0, 1, 64'h0000_0013_0000_0093);
      // LS store
      txn(1'b1, 1'b1, 32'h8000_0020, 64'h0000_0000_DEAD_BEEF, 8'h0F, 0, 0, 64'h0);
      // Delayed grant, delayed response
      txn(1'b1, 1'b0, 32'h8000_0ABC, 64'h0, 8'h00, 3, 2, 64'hCAFE_F00D_1234_5678);

      // Tie with both requests held; start from reset so LS wins first
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      if_req = 1'b1; if_addr = 32'h3000_0000;
      ls_req = 1'b1; ls_addr = 32'h4000_0000; ls_we = 1'b0;
      mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'h0A0B_0C0D_0E0F_1011;
      for (int k = 0; k < 4; k++) begin
`ifdef YSYX_25060170_ARB_RR_EN
         exp_ls = ((k % 2) == 0);
`else
         exp_ls = 1'b1;
`endif
         @(negedge clk);
         check("tie_idle_busy", 64'(busy_o), '0);
         next_cycle();
         @(negedge clk);
         check("tie_ls_gnt", 64'(ls_gnt_o), 64'(exp_ls));
         check("tie_if_gnt", 64'(if_gnt_o), 64'(!exp_ls));
         check("tie_addr", 64'(mem_addr_o), exp_ls ? 64'h4000_0000 : 64'h3000_0000);
         next_cycle();
         push_rsp(exp_ls, 64'h0A0B_0C0D_0E0F_1011, 1'b0);
         @(negedge clk);
         next_cycle();
      end
      if_req = 1'b0; ls_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
      next_cycle();

      // Timeout after 4 RESP cycles, then a late response in IDLE
      ls_req = 1'b1; ls_addr = 32'h8000_0100; ls_we = 1'b0;
      next_cycle();
      mem_gnt = 1'b1;
      @(negedge clk);
      check("tmo_gnt", 64'(ls_gnt_o), 64'd1);
      next_cycle();
      mem_gnt = 1'b0; ls_req = 1'b0; mem_rdata = '1;
      for (int c = 1; c <= 4; c++) begin
         if (c == 4) push_rsp(1'b1, '0, 1'b1);
         @(negedge clk);
         check("tmo_busy", 64'(busy_o), 64'd1);
         check("tmo_err_pulse", 64'(ls_err_o), 64'(c == 4));
         next_cycle();
      end
      mem_rvalid = 1'b1;
      @(negedge clk);
      check("late_busy", 64'(busy_o), '0);
      check("late_ls_rvalid", 64'(ls_rvalid_o), '0);
      next_cycle();
      mem_rvalid = 1'b0;

      // Reset while in RESP drops the transaction
      ls_req = 1'b1; ls_addr = 32'h8000_0200;
      next_cycle();
      mem_gnt = 1'b1;
      next_cycle();
      mem_gnt = 1'b0; ls_req = 1'b0;
      rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'h5555_AAAA_5555_AAAA;
      @(negedge clk);
      check("rst_resp_rvalid", 64'(ls_rvalid_o), '0);
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      check("rst_outputs", 64'(|{mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
                                  if_gnt_o, if_rvalid_o, if_err_o, if_rdata_o,
                                  ls_gnt_o, ls_rvalid_o, ls_err_o, ls_rdata_o}), '0);
      check("rst_busy", 64'(busy_o), '0);
      next_cycle();
      mem_rvalid = 1'b0;
      repeat (2) next_cycle();

      check("sb_empty", 64'(sb_q.size()), '0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

endmodule

// File: doc/ysyx_25060170_mem_arb.md
# ysyx_25060170_mem_arb

Two-requester arbiter sharing the single data-memory port between the instruction fetch unit (read-only) and the load/store unit (read/write). It sits between IFU/LSU and the memory/bus interface. It grants one transaction at a time, routes the response back to its owner, and aborts any transaction whose response never arrives. Only one transaction is outstanding at any time.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 64, data width; byte-mask width is `DATA_W/8`
- `TIMEOUT`, 255, cycles spent in RESP without `mem_rvalid` before abort (1..65535)

- `clk` in 1: the only clock
- `rst` in 1: synchronous, active-high reset
- `if_req` in 1: fetch request; held with `if_addr` until `if_gnt`
- `if_addr` in ADDR_W: fetch address
- `if_gnt` out 1: one-cycle pulse; request accepted by memory
- `if_rvalid` out 1: one-cycle pulse; `if_rdata` valid
- `if_rdata` out DATA_W: fetch data
- `if_err` out 1: one-cycle pulse with `if_rvalid` on timeout
- `ls_req` in 1: load/store request; held with its payload until `ls_gnt`
- `ls_we` in 1: 1 = store
- `ls_addr` in ADDR_W: address
- `ls_wdata` in DATA_W: store data
- `ls_wmask` in DATA_W/8: store byte mask
- `ls_gnt`, `ls_rvalid`, `ls_err` out 1 each: same semantics as the IF outputs
- `ls_rdata` out DATA_W: load data
- `mem_req` out 1: request to memory
- `mem_we` out 1: write enable
- `mem_addr` out ADDR_W: address
- `mem_wdata` out DATA_W: write data
- `mem_wmask` out DATA_W/8: byte mask
- `mem_gnt` in 1: memory accepts `mem_req` this cycle
- `mem_rvalid` in 1: response (read data or write ack)
- `mem_rdata` in DATA_W: read data
- `busy` out 1: FSM not in IDLE

## Operation
- FSM states:
  - IDLE: if any request, pick an owner, register it, go to REQ.
  - REQ: drive `mem_req=1`. Payload is muxed combinationally from the registered owner's held inputs. IF owner forces `mem_we=0` and `mem_wmask=0`. When `mem_gnt` is high: pulse owner `*_gnt`, clear the timer, go to RESP.
  - RESP: when `mem_rvalid` is high: pulse owner `*_rvalid`, route `mem_rdata` to owner `*_rdata`, go to IDLE. Otherwise increment the timer. When the timer reaches `TIMEOUT-1` with no rvalid: pulse owner `*_rvalid` and `*_err`, force rdata to 0, go to IDLE.
- `mem_rvalid` outside RESP is ignored.
- A late response after a timeout is discarded.
- A write still produces a `*_rvalid` pulse, which acts as the store-complete ack.
- Non-owner `*_gnt`, `*_rvalid` and `*_err` are always 0. Non-owner `*_rdata` is 0.
- If a requester drops `req` while in REQ, that is a protocol violation. The arbiter still completes the transaction it started.
- Simultaneous `if_req` and `ls_req` in IDLE: resolved by the arbitration policy (see Configuration).
- Timer is 16 bits wide and saturates. It is only meaningful in RESP.

## Timing
- Reset values:
  - FSM is in IDLE, timer is 0.
  - All outputs are 0: `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_wmask`, every `*_gnt`, `*_rvalid`, `*_err`, `*_rdata`, and `busy`.
  - The last-served flag resets to IF, so LS wins the first tie.
- Request seen in IDLE at cycle 0: `mem_req` asserts at cycle 1.
  - If `mem_gnt` is also high at cycle 1, `*_gnt` pulses at cycle 1.
  - Earliest `mem_rvalid` is at cycle 2, and `*_rvalid` pulses in the same cycle (combinational route).
  - FSM is back in IDLE at cycle 3.
- Throughput: one transaction per 3 cycles minimum, because IDLE always costs one cycle.
- `mem_req` stays high in REQ until `mem_gnt`. It never drops mid-handshake.
- A timeout abort occurs after exactly `TIMEOUT` RESP cycles without rvalid.
- Reset mid-operation (REQ or RESP): the FSM goes to IDLE the next cycle, the in-flight transaction is dropped with no pulses, and memory is reset by the same `rst`.

## Configuration
- `YSYX_25060170_ARB_RR_EN` defined: round-robin.
  - On a tie, serve the requester that was not served last.
  - The last-served flag updates on every IDLE→REQ transition.
  - Neither requester waits more than one foreign transaction.
- `YSYX_25060170_ARB_RR_EN` undefined: fixed priority, LS always wins. The last-served flag is not built.

## Structure
- Shared package `ysyx_25060170_arb_pkg` holds:
  - the state encoding (IDLE=2'd0, REQ=2'd1, RESP=2'd2);
  - the owner encoding (OWN_IF=1'b0, OWN_LS=1'b1);
  - the default widths `ADDR_W` and `DATA_W`.
- One sub-module, `ysyx_25060170_arb_pick`: combinational winner selection from `if_req`, `ls_req` and the last-served flag. It contains the macro-dependent logic.
- FSM, timer and muxes live in the top module.

## Test plan
1. LS load only: `ls_req=1`, `ls_addr=0x80000010`, `mem_gnt=1` at cycle 1, `mem_rvalid=1` with `mem_rdata=0x1122334455667788` at cycle 2.
   - Expect `ls_gnt` at cycle 1, and `ls_rvalid` with that data at cycle 2.
   - Expect `if_*` outputs at 0 throughout.
2. Tie, round-robin build: `if_req` and `ls_req` held high, memory grants and responds immediately.
   - Expect grants in the order LS, IF, LS, IF.
   - Fixed-priority build: LS is granted repeatedly and `if_gnt` never pulses.
3. LS store: `ls_we=1`, `ls_wmask=8'h0F`, `ls_wdata=0xDEADBEEF`.
   - Expect `mem_we=1`, `mem_wmask=8'h0F`, `mem_wdata=0xDEADBEEF` in REQ, then `ls_rvalid` on the ack.
4. Timeout: `TIMEOUT=4`, grant given, `mem_rvalid` never asserted.
   - Expect `ls_rvalid=1`, `ls_err=1`, `ls_rdata=0` on the 4th RESP cycle, then IDLE.
   - A late `mem_rvalid` is ignored.
5. Delayed grant: `mem_gnt` held low for 3 cycles.
   - Expect `mem_req` and its payload held stable for all 3 cycles, and `ls_gnt` only on the grant cycle.
6. Reset in RESP: `rst` high for 1 cycle.
   - Expect all outputs 0 and `busy=0` the next cycle, and no `rvalid` pulse for the dropped transaction.
